// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   OVERSAMPLE, MIN_LEN, MAX_LEN  line timing and legal data-length range
//   CNT_W, CNT_MAX                width and terminal value of the per-bit
//                                 oversample counter
//   tx_state_e                    transmitter frame-sequencing states
//   uart_len_ok()                 true when a data length is in MIN_LEN..MAX_LEN
//   uart_parity()                 parity over the first `length` data bits
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MIN_LEN    = 5;
  localparam int MAX_LEN    = 8;

  localparam int             CNT_W   = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5,
    DONE   = 3'd6
  } tx_state_e;

  function automatic logic uart_len_ok(input logic [3:0] length);
    return (length >= 4'(MIN_LEN)) && (length <= 4'(MAX_LEN));
  endfunction

  // Bits at positions length..7 are not on the wire, so they are excluded.
  // parity_type = 1 gives the XOR of the data bits, 0 gives the XNOR.
  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic [3:0] length,
                                       input logic       parity_type);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(length)) p = p ^ data[i];
    end
    return parity_type ? p : ~p;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter with programmable frame format.
//
// Frame: start(0), `length` data bits LSB first, optional parity, one or two
// stop bits(1). Every serial bit lasts OVERSAMPLE tx_clk cycles. A final
// one-cycle DONE state separates frames, so back-to-back requests leave at
// least one extra idle-high cycle between the last stop bit and the next
// start bit.
//
// Ports:
//   tx_clk       in   clock, OVERSAMPLE cycles per serial bit
//   rst          in   synchronous active-high reset, aborts any frame
//   tx_start     in   frame request, only looked at in IDLE
//   tx_data[7:0] in   payload, bit 0 sent first
//   length[3:0]  in   data bits per frame, legal 5..8
//   parity_type  in   1 = XOR parity, 0 = XNOR parity
//   parity_en    in   1 = append a parity bit
//   stop2        in   1 = two stop bits
//   tx           out  registered serial line, idle high
//   tx_busy      out  high from the cycle after acceptance through DONE
//   tx_done      out  one-cycle pulse in the DONE cycle
//   tx_err       out  one-cycle pulse after a request with an illegal length
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
(
  input  logic       tx_clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic [3:0] length,
  input  logic       parity_type,
  input  logic       parity_en,
  input  logic       stop2,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  tx_state_e        state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [2:0]       bit_count, bit_next;

  // Frame parameters captured at acceptance.
  logic [7:0]       data_q;
  logic [3:0]       len_q;
  logic             par_en_q;
  logic             stop2_q;
  logic             par_bit_q;

  logic             tx_next;
  logic             busy_next;
  logic             done_next;
  logic             err_next;
  logic             accept;
  logic             reject;
  logic             bit_end;
  logic             last_data_bit;

  // ---------------------------------------------------------------------------
  // Next-state, counters and next output values
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_next    = state;
    count_next    = count;
    bit_next      = bit_count;
    accept        = 1'b0;
    reject        = 1'b0;
    bit_end       = (count == CNT_MAX);
    last_data_bit = ({1'b0, bit_count} == (len_q - 4'd1));

    case (state)
      IDLE: begin
        count_next = '0;
        bit_next   = '0;
        if (tx_start) begin
          if (uart_len_ok(length)) begin
            accept     = 1'b1;
            state_next = START;
          end else begin
            reject     = 1'b1;
          end
        end
      end

      START: begin
        if (bit_end) state_next = DATA;
      end

      DATA: begin
        if (bit_end) begin
          if (last_data_bit) begin
            bit_next   = '0;
            state_next = par_en_q ? PARITY : STOP1;
          end else begin
            bit_next   = bit_count + 3'd1;
          end
        end
      end

      PARITY: begin
        if (bit_end) state_next = STOP1;
      end

      STOP1: begin
        if (bit_end) state_next = stop2_q ? STOP2 : DONE;
      end

      STOP2: begin
        if (bit_end) state_next = DONE;
      end

      DONE: begin
        count_next = '0;
        state_next = IDLE;
      end

      default: begin
        count_next = '0;
        bit_next   = '0;
        state_next = IDLE;
      end
    endcase

    // The oversample counter only runs in the serial-bit states and restarts
    // at zero on every bit boundary.
    if (state inside {START, DATA, PARITY, STOP1, STOP2}) begin
      count_next = bit_end ? '0 : count + 1'b1;
    end

    // tx is decoded from the *next* state so the line changes on the same
    // edge that the state register does.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[bit_next];
      PARITY:  tx_next = par_bit_q;
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
    err_next  = reject;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge tx_clk) begin
    // NOTE: sequential state is assigned with <= so every register samples the
    // values from before this edge, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      bit_count <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      bit_count <= bit_next;
      tx        <= tx_next;
      tx_busy   <= busy_next;
      tx_done   <= done_next;
      tx_err    <= err_next;
    end
  end

  // NOTE: the frame-parameter registers carry no reset; they are only read
  // after an acceptance has loaded them, so their power-up value is never
  // observable and leaving them reset-free keeps them off the reset tree.
  // The parity bit is computed once here from the live inputs rather than
  // from the latched copies, which keeps the parity tree off the tx path.
  always_ff @(posedge tx_clk) begin
    if (accept && !rst) begin
      data_q    <= tx_data;
      len_q     <= length;
      par_en_q  <= parity_en;
      stop2_q   <= stop2;
      par_bit_q <= uart_parity(tx_data, length, parity_type);
    end
  end

endmodule : uart_tx
